// File: rtl/detection_monitor_pkg.sv
// Shared state encoding, default widths and saturation helper for the
// detection window monitor.
package detection_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 8;

  // All-ones value of a w-bit unsigned counter (w < 32).
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/det_sat_counter.sv
// Saturating up-counter. clr restarts the count; clr together with inc
// restarts it at one, so an event on the restart edge is not lost.
module det_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: non-blocking assignments for every flop, so all registers in the
  // design update together from the values present before the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= W'(inc);
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/detection_window_monitor.sv
// Consumes the sequence detector strobe: total/window detection counts,
// inter-detection gap, and a sticky per-window threshold alarm.
module detection_window_monitor
  import detection_monitor_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_W   = GAP_W_DEF,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             detect_in,
  input  logic             alarm_ack,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] window_count,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_valid,
  output logic             alarm
);

  localparam int               TW         = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(sat_max(CNT_W));
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(sat_max(GAP_W));
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);

  state_e           state;
  logic [TW-1:0]    timer;
  logic             first_seen;
  logic [GAP_W-1:0] gap_cnt;

  logic             active;
  logic             counted_det;
  logic             rollover;
  logic             thresh_hit;
  logic             win_clr;
  logic             win_inc;
  logic             gap_clr;
  logic             gap_inc;
  logic [CNT_W-1:0] win_plus;
  logic [GAP_W-1:0] gap_plus;

  // NOTE: every signal is assigned on every pass through this block, so no
  // latch can be inferred.
  always_comb begin
    active      = (state != IDLE) && enable && !clear;
    counted_det = active && detect_in;
    rollover    = active && (timer == TIMER_LAST);
    win_plus    = (window_count == CNT_MAX) ? window_count : window_count + CNT_W'(1);
    gap_plus    = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + GAP_W'(1);
    thresh_hit  = counted_det && (state == MONITOR) && (win_plus == THRESH_C);
    // A detection on the rollover edge belongs to the ending window, so the
    // new window starts empty even if it coincides with an acknowledge.
    win_clr     = clear || ((state != IDLE) && !enable) || rollover
                  || (active && (state == ALARM) && alarm_ack);
    win_inc     = counted_det && !rollover;
    gap_clr     = clear || counted_det;
    gap_inc     = active && !detect_in;
  end

  det_sat_counter #(.W(CNT_W)) u_total (
    .clock (clock),
    .reset (reset),
    .inc   (counted_det),
    .clr   (clear),
    .count (total_count)
  );

  det_sat_counter #(.W(CNT_W)) u_window (
    .clock (clock),
    .reset (reset),
    .inc   (win_inc),
    .clr   (win_clr),
    .count (window_count)
  );

  det_sat_counter #(.W(GAP_W)) u_gap (
    .clock (clock),
    .reset (reset),
    .inc   (gap_inc),
    .clr   (gap_clr),
    .count (gap_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      first_seen <= 1'b0;
      last_gap   <= '0;
      gap_valid  <= 1'b0;
      alarm      <= 1'b0;
    end else if (clear) begin
      state      <= enable ? MONITOR : IDLE;
      timer      <= '0;
      first_seen <= 1'b0;
      last_gap   <= '0;
      gap_valid  <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      gap_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (enable) state <= MONITOR;
        end
        MONITOR, ALARM: begin
          if (!enable) begin
            state <= IDLE;
            alarm <= 1'b0;
            timer <= '0;
          end else begin
            timer <= rollover ? '0 : timer + TW'(1);
            if (detect_in) begin
              first_seen <= 1'b1;
              if (first_seen) begin
                last_gap  <= gap_plus;
                gap_valid <= 1'b1;
              end
            end
            if ((state == ALARM) && alarm_ack) begin
              state <= MONITOR;
              alarm <= 1'b0;
            end else if (thresh_hit) begin
              state <= ALARM;
              alarm <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          alarm <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detection_window_monitor.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs for
// two monitor instances (8-bit / threshold 3 and 4-bit / threshold 15).
module tb_detection_window_monitor;

  localparam int WIN = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic en0, clr0, det0, ack0;
  logic en1, clr1, det1, ack1;
  logic [7:0] total0, win0, last0;
  logic       gv0, alarm0;
  logic [3:0] total1, win1, last1;
  logic       gv1, alarm1;

  detection_window_monitor #(.CNT_W(8), .GAP_W(8), .WIN_LEN(WIN), .THRESH(3)) dut0 (
    .clock(clock), .reset(reset), .enable(en0), .clear(clr0), .detect_in(det0),
    .alarm_ack(ack0), .total_count(total0), .window_count(win0), .last_gap(last0),
    .gap_valid(gv0), .alarm(alarm0)
  );

  detection_window_monitor #(.CNT_W(4), .GAP_W(4), .WIN_LEN(WIN), .THRESH(15)) dut1 (
    .clock(clock), .reset(reset), .enable(en1), .clear(clr1), .detect_in(det1),
    .alarm_ack(ack1), .total_count(total1), .window_count(win1), .last_gap(last1),
    .gap_valid(gv1), .alarm(alarm1)
  );

  typedef struct {
    int on, alarm, total, win, gap, seen, last, phase, gv;
  } model_t;

  typedef struct {
    int total, win, last, gv, alarm;
  } exp_t;

  model_t m[2];
  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   e0, e1;
  int     cmax[2] = '{255, 15};
  int     gmax[2] = '{255, 15};
  int     thr[2]  = '{3, 15};
  int     n_checks = 0;
  int     n_errors = 0;
  int     gv1_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset(input int id);
    m[id] = '{default: 0};
  endfunction

  // One clock edge of the monitor, written from the behavioural rules.
  function automatic void mstep(input int id, input bit en, input bit clr,
                                input bit det, input bit ack);
    int nwin;
    bit ending;
    m[id].gv = 0;
    if (clr) begin
      model_reset(id);
      m[id].on = en;
      return;
    end
    if (m[id].on == 0) begin
      if (en) begin
        m[id].on    = 1;
        m[id].phase = 0;
        m[id].win   = 0;
      end
      return;
    end
    if (!en) begin
      m[id].on    = 0;
      m[id].alarm = 0;
      m[id].win   = 0;
      m[id].phase = 0;
      return;
    end
    ending = (m[id].phase == WIN - 1);
    nwin   = m[id].win;
    if (det) begin
      m[id].total = imin(m[id].total + 1, cmax[id]);
      nwin        = imin(m[id].win + 1, cmax[id]);
      if (m[id].seen != 0) begin
        m[id].last = imin(m[id].gap + 1, gmax[id]);
        m[id].gv   = 1;
      end
      m[id].gap  = 0;
      m[id].seen = 1;
    end else begin
      m[id].gap = imin(m[id].gap + 1, gmax[id]);
    end
    if (m[id].alarm != 0) begin
      if (ack) begin
        m[id].alarm = 0;
        nwin        = det ? 1 : 0;
      end
    end else if (det && (nwin == thr[id])) begin
      m[id].alarm = 1;
    end
    if (ending) nwin = 0;
    m[id].win   = nwin;
    m[id].phase = (m[id].phase + 1) % WIN;
  endfunction

  // Called just after a falling edge; predicts the next rising edge and
  // returns just after the following falling edge.
  task automatic tick();
    mstep(0, en0, clr0, det0, ack0);
    mstep(1, en1, clr1, det1, ack1);
    q0.push_back('{m[0].total, m[0].win, m[0].last, m[0].gv, m[0].alarm});
    q1.push_back('{m[1].total, m[1].win, m[1].last, m[1].gv, m[1].alarm});
    @(negedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (gv1) gv1_cnt++;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check("d0_total", total0, e0.total);
      check("d0_window", win0, e0.win);
      check("d0_last_gap", last0, e0.last);
      check("d0_gap_valid", gv0, e0.gv);
      check("d0_alarm", alarm0, e0.alarm);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("d1_total", total1, e1.total);
      check("d1_window", win1, e1.win);
      check("d1_last_gap", last1, e1.last);
      check("d1_gap_valid", gv1, e1.gv);
      check("d1_alarm", alarm1, e1.alarm);
    end
  end

  initial begin
    reset = 1'b0;
    {en0, clr0, det0, ack0} = 4'b0;
    {en1, clr1, det1, ack1} = 4'b0;
    model_reset(0);
    model_reset(1);
    #11;
    check("rst_total0", total0, 0);
    check("rst_window0", win0, 0);
    check("rst_gap0", last0, 0);
    check("rst_gv0", gv0, 0);
    check("rst_alarm0", alarm0, 0);
    check("rst_total1", total1, 0);
    check("rst_alarm1", alarm1, 0);
    reset = 1'b1;

    // Detections at window cycles 4, 8, 11; acknowledge at 13.
    en0 = 1'b1;
    tick();
    for (int c = 0; c < WIN; c++) begin
      det0 = (c == 4) || (c == 8) || (c == 11);
      ack0 = (c == 13);
      tick();
      if (c == 8) begin
        check("A_gap_4", last0, 4);
        check("A_gv_first", gv0, 1);
      end
      if (c == 9) check("A_gv_pulse", gv0, 0);
      if (c == 11) begin
        check("A_gap_3", last0, 3);
        check("A_alarm_on", alarm0, 1);
        check("A_total_3", total0, 3);
      end
      if (c == 13) begin
        check("A_ack_alarm", alarm0, 0);
        check("A_ack_window", win0, 0);
      end
    end
    det0 = 1'b0;
    ack0 = 1'b0;

    // Two detections per window for three windows: never alarms.
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < WIN; c++) begin
        det0 = (c == 2) || (c == 9);
        tick();
        if (c == 14) check("B_window_2", win0, 2);
        if (c == 15) begin
          check("B_roll_window", win0, 0);
          check("B_no_alarm", alarm0, 0);
        end
      end
    end
    det0 = 1'b0;
    check("B_total_6", total0, 6);

    // Priority: clear beats detection, enable-low beats alarm, ack plus detect.
    clr0 = 1'b1;
    det0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check("C_clr_total", total0, 0);
    check("C_clr_gv", gv0, 0);
    repeat (3) tick();
    check("C_alarm_set", alarm0, 1);
    det0 = 1'b0;
    en0  = 1'b0;
    tick();
    check("C_en_low_alarm", alarm0, 0);
    check("C_en_low_window", win0, 0);
    en0 = 1'b1;
    tick();
    det0 = 1'b1;
    repeat (3) tick();
    ack0 = 1'b1;
    tick();
    check("C_ack_det_window", win0, 1);
    check("C_ack_det_alarm", alarm0, 0);
    check("C_ack_det_total", total0, 7);
    ack0 = 1'b0;
    det0 = 1'b0;

    // Asynchronous reset mid-cycle with a busy monitor.
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    det0 = 1'b1;
    repeat (5) tick();
    det0 = 1'b0;
    check("D_total_5", total0, 5);
    check("D_alarm_1", alarm0, 1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    model_reset(0);
    model_reset(1);
    #1;
    check("D_async_total", total0, 0);
    check("D_async_window", win0, 0);
    check("D_async_gap", last0, 0);
    check("D_async_gv", gv0, 0);
    check("D_async_alarm", alarm0, 0);
    {en0, clr0, det0, ack0} = 4'b0;
    @(negedge clock);
    #1;
    reset = 1'b1;

    // 4-bit instance: saturation of counts and of the gap.
    en1 = 1'b1;
    tick();
    det1    = 1'b1;
    gv1_cnt = 0;
    repeat (20) tick();
    check("E_total_sat", total1, 15);
    check("E_gap_1", last1, 1);
    check("E_gv_count", gv1_cnt, 19);
    det1 = 1'b0;
    repeat (5) tick();
    det1 = 1'b1;
    tick();
    det1 = 1'b0;
    repeat (39) tick();
    det1 = 1'b1;
    tick();
    check("E_gap_sat", last1, 15);
    check("E_gap_sat_gv", gv1, 1);
    det1 = 1'b0;

    // Randomised traffic on both instances.
    for (int i = 0; i < 2000; i++) begin
      en0  = ($urandom % 16) != 0;
      clr0 = ($urandom % 64) == 0;
      det0 = ($urandom % 4) == 0;
      ack0 = ($urandom % 8) == 0;
      en1  = ($urandom % 16) != 0;
      clr1 = ($urandom % 64) == 0;
      det1 = ($urandom % 2) == 0;
      ack1 = ($urandom % 8) == 0;
      tick();
    end
    {en0, clr0, det0, ack0} = 4'b0;
    {en1, clr1, det1, ack1} = 4'b0;
    tick();
    check("F_q0_drained", q0.size(), 0);
    check("F_q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/detection_window_monitor.md
Name: detection_window_monitor

Overview:
Downstream consumer of the Moore sequence detector's one-cycle detect output; input detect_in connects directly to detector_out.
- Counts detections (total and per fixed window).
- Measures the gap between consecutive detections.
- Raises a sticky alarm when detections within one window reach a threshold.
- Status outputs feed the debug/status register block.

Parameters:
CNT_W, 8, width of total_count and window_count
GAP_W, 8, width of gap counter and last_gap
WIN_LEN, 16, window length in clock cycles (>=2)
THRESH, 3, detections per window that trigger alarm (1..2^CNT_W-1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  monitoring enable
clear  input  1  synchronous clear of all statistics
detect_in  input  1  detection strobe from sequence detector; each high cycle = one detection
alarm_ack  input  1  acknowledges and clears alarm
total_count  output  CNT_W  saturating detection count since reset/clear
window_count  output  CNT_W  saturating detections in current window
last_gap  output  GAP_W  clock edges between the last two detections, saturating
gap_valid  output  1  one-cycle pulse when last_gap updates
alarm  output  1  threshold reached; held until ack/enable low/clear

Behaviour:
- All outputs registered. Reset (asynchronous): state IDLE; all outputs 0; window timer, gap counter and first_seen all 0.
- States: IDLE=0, MONITOR=1, ALARM=2.
- Priority per edge: clear > enable low > alarm_ack > detection.
- IDLE: detect_in ignored; counters hold. enable=1 -> MONITOR next edge, with window timer=0 and window_count=0; total_count and last_gap retained.
- Window timer: runs in MONITOR and ALARM, 0..WIN_LEN-1. On the edge where timer==WIN_LEN-1, timer and window_count go to 0. A detection sampled on that edge counts toward the ending window (threshold check applies), then window_count=0.
- Detection (detect_in=1 at an edge, state MONITOR or ALARM), effects on that same edge:
  - total_count+1 and window_count+1, both saturating at all-ones.
  - If first_seen=1: last_gap <= gap_cnt+1 (saturating at 2^GAP_W-1) and gap_valid=1 for one cycle; gap_cnt <= 0.
  - first_seen <= 1.
- Gap counter: increments (saturating) on every non-detect edge in MONITOR or ALARM. Example: detections at edges 10 and 14 give last_gap=4.
- MONITOR -> ALARM: when the updated window_count equals THRESH; alarm=1 on that same edge, so latency is 0 cycles after the sampling edge.
- ALARM:
  - Counting, gap measurement and window roll continue; further threshold hits are ignored.
  - alarm_ack=1 -> MONITOR; alarm=0 and window_count=0 on that edge. A detection on the same edge sets window_count=1 and still updates total_count and gap.
- enable=0 in MONITOR or ALARM -> IDLE; alarm=0; window_count=0; gap_cnt holds.
- clear=1: total_count, window_count, last_gap, gap_valid, alarm, timer, gap_cnt and first_seen all go to 0. Next state is MONITOR if enable=1, else IDLE. A detection on the clear edge is discarded.
- gap_valid is 0 in every cycle without a counted detection.
- Reset deassertion mid-operation: start from the reset state; no pending detection survives.

Decomposition:
- Package detection_monitor_pkg:
  - State encoding constants: IDLE, MONITOR, ALARM (2 bits).
  - Saturation-max helper constants for CNT_W and GAP_W.
- One sub-module, det_sat_counter:
  - Parameterised width.
  - Inputs: inc, clr.
  - Saturating register, instantiated for total_count, window_count and gap_cnt.
- Window timer and FSM stay in the top level.

Test Plan:
- Async reset: with total_count=5 and alarm=1, drive reset=0 mid-cycle -> all outputs 0 immediately, before the next clock edge.
- WIN_LEN=16, THRESH=3; enable=1; detections at window cycles 4, 8, 11:
  - total_count=3 and last_gap=4 then 3; gap_valid pulses twice.
  - alarm=1 on the 3rd detection edge.
  - alarm_ack -> alarm=0 and window_count=0 next edge.
- Two detections per window for 3 windows -> alarm never rises; total_count=6; window_count returns to 0 at each rollover.
- CNT_W=4, GAP_W=4, THRESH=15:
  - detect_in held high 20 cycles -> total_count sticks at 15; last_gap=1; gap_valid high 19 cycles.
  - Then two detections 40 cycles apart -> last_gap=15.
- Priority checks:
  - clear with detect_in=1 on the same edge -> total_count=0, gap_valid=0.
  - enable=0 while in ALARM -> IDLE, alarm=0.
  - alarm_ack with a detection on the same edge -> window_count=1.
